// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//   General-purpose register file for the picoMIPS datapath with a pending-write
//   scoreboard. Two combinational read ports (d, s) and one synchronous write
//   port. Each register carries a busy bit that the issue stage sets through
//   the reserve port and that the writeback stage clears by writing.
//   Options: hardwired-zero R0 (ZERO_REG) and write->read bypass (BYPASS).
//
// Ports
//   clk              clock, all state updates on posedge
//   reset            asynchronous active-high clear of data and busy bits
//   writeEnIn        write strobe (writeback)
//   wAddressIn       write address
//   dataIn           write data
//   dAddressIn       read port d address
//   sAddressIn       read port s address
//   reserveEnIn      mark reserveAddressIn as pending write (issue)
//   reserveAddressIn register to reserve
//   dOut / sOut      read data, ports d and s
//   dBusyOut/sBusyOut addressed register has a pending write
//   stallOut         dBusyOut | sBusyOut
//   busyVectorOut    registered scoreboard bits, bit i = register i
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter int N        = 8,
    parameter int R_SIZE   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 writeEnIn,
    input  logic [R_SIZE-1:0]    wAddressIn,
    input  logic [N-1:0]         dataIn,
    input  logic [R_SIZE-1:0]    dAddressIn,
    input  logic [R_SIZE-1:0]    sAddressIn,
    input  logic                 reserveEnIn,
    input  logic [R_SIZE-1:0]    reserveAddressIn,
    output logic [N-1:0]         dOut,
    output logic [N-1:0]         sOut,
    output logic                 dBusyOut,
    output logic                 sBusyOut,
    output logic                 stallOut,
    output logic [2**R_SIZE-1:0] busyVectorOut
);

    localparam int DEPTH = 2**R_SIZE;

    logic [N-1:0]      w_regs [DEPTH];
    logic [DEPTH-1:0]  w_busy;

    // One storage element plus busy bit per register. The array uses an async
    // reset and two read ports, so it is built from flops rather than RAM.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
                assign w_busy[gi] = 1'b0;
            end else begin : g_store
                logic [N-1:0] r_data;
                logic         r_busy;
                logic         w_wr_hit;
                logic         w_rsv_hit;

                assign w_wr_hit  = writeEnIn   && (wAddressIn       == R_SIZE'(gi));
                assign w_rsv_hit = reserveEnIn && (reserveAddressIn == R_SIZE'(gi));

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_data <= '0;
                        r_busy <= 1'b0;
                    end else begin
                        if (w_wr_hit) begin
                            r_data <= dataIn;
                        end
                        // A new reservation outranks the completing write:
                        // the register stays pending for the newer producer.
                        if (w_rsv_hit) begin
                            r_busy <= 1'b1;
                        end else if (w_wr_hit) begin
                            r_busy <= 1'b0;
                        end
                    end
                end

                assign w_regs[gi] = r_data;
                assign w_busy[gi] = r_busy;
            end
        end
    endgenerate

    // Read ports: index 0 = d, index 1 = s.
    logic [R_SIZE-1:0] w_rd_addr [2];
    logic [N-1:0]      w_rd_data [2];
    logic              w_rd_busy [2];

    assign w_rd_addr[0] = dAddressIn;
    assign w_rd_addr[1] = sAddressIn;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            always_comb begin
                w_rd_data[gi] = w_regs[w_rd_addr[gi]];
                w_rd_busy[gi] = w_busy[w_rd_addr[gi]];
                // Forwarded data is by definition no longer pending.
                if (BYPASS != 0 && writeEnIn && (wAddressIn == w_rd_addr[gi])) begin
                    w_rd_data[gi] = dataIn;
                    w_rd_busy[gi] = 1'b0;
                end
                // Hardwired zero wins over forwarding of a write to R0.
                if (ZERO_REG != 0 && w_rd_addr[gi] == '0) begin
                    w_rd_data[gi] = '0;
                    w_rd_busy[gi] = 1'b0;
                end
            end
        end
    endgenerate

    assign dOut          = w_rd_data[0];
    assign sOut          = w_rd_data[1];
    assign dBusyOut      = w_rd_busy[0];
    assign sBusyOut      = w_rd_busy[1];
    assign stallOut      = w_rd_busy[0] | w_rd_busy[1];
    assign busyVectorOut = w_busy;

endmodule

// File: tb/tb_register_file_sb.sv
// -----------------------------------------------------------------------------
// tb_register_file_sb
//   Directed bench for register_file_sb. Instance A: defaults (zero R0, bypass).
//   Instance B: same inputs, ZERO_REG=0 and BYPASS=0. Instance C: N=16,
//   R_SIZE=4 with defaults. Inputs change on negedge, outputs are checked 1 ns
//   later, state updates on the following posedge.
// -----------------------------------------------------------------------------
module tb_register_file_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Shared stimulus for A and B
    logic       we, re;
    logic [2:0] wa, ra, da, sa;
    logic [7:0] din;

    logic [7:0] a_dout, a_sout, a_bvec, b_dout, b_sout, b_bvec;
    logic       a_dbusy, a_sbusy, a_stall, b_dbusy, b_sbusy, b_stall;

    // Stimulus for C
    logic        c_we, c_re;
    logic [3:0]  c_wa, c_ra, c_da, c_sa;
    logic [15:0] c_din, c_dout, c_sout, c_bvec;
    logic        c_dbusy, c_sbusy, c_stall;

    register_file_sb #(.N(8), .R_SIZE(3), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(rst), .writeEnIn(we), .wAddressIn(wa), .dataIn(din),
        .dAddressIn(da), .sAddressIn(sa), .reserveEnIn(re), .reserveAddressIn(ra),
        .dOut(a_dout), .sOut(a_sout), .dBusyOut(a_dbusy), .sBusyOut(a_sbusy),
        .stallOut(a_stall), .busyVectorOut(a_bvec)
    );

    register_file_sb #(.N(8), .R_SIZE(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(rst), .writeEnIn(we), .wAddressIn(wa), .dataIn(din),
        .dAddressIn(da), .sAddressIn(sa), .reserveEnIn(re), .reserveAddressIn(ra),
        .dOut(b_dout), .sOut(b_sout), .dBusyOut(b_dbusy), .sBusyOut(b_sbusy),
        .stallOut(b_stall), .busyVectorOut(b_bvec)
    );

    register_file_sb #(.N(16), .R_SIZE(4), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .reset(rst), .writeEnIn(c_we), .wAddressIn(c_wa), .dataIn(c_din),
        .dAddressIn(c_da), .sAddressIn(c_sa), .reserveEnIn(c_re), .reserveAddressIn(c_ra),
        .dOut(c_dout), .sOut(c_sout), .dBusyOut(c_dbusy), .sBusyOut(c_sbusy),
        .stallOut(c_stall), .busyVectorOut(c_bvec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one cycle of A/B stimulus at negedge, leave 1 ns for settling.
    task automatic step_ab(input logic we_i, input logic [2:0] wa_i, input logic [7:0] din_i,
                           input logic re_i, input logic [2:0] ra_i,
                           input logic [2:0] da_i, input logic [2:0] sa_i);
        @(negedge clk);
        we = we_i; wa = wa_i; din = din_i; re = re_i; ra = ra_i; da = da_i; sa = sa_i;
        #1;
    endtask

    task automatic step_c(input logic we_i, input logic [3:0] wa_i, input logic [15:0] din_i,
                          input logic re_i, input logic [3:0] ra_i,
                          input logic [3:0] da_i, input logic [3:0] sa_i);
        @(negedge clk);
        c_we = we_i; c_wa = wa_i; c_din = din_i; c_re = re_i; c_ra = ra_i; c_da = da_i; c_sa = sa_i;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we = 0; re = 0; wa = 0; ra = 0; da = 0; sa = 0; din = 0;
        c_we = 0; c_re = 0; c_wa = 0; c_ra = 0; c_da = 0; c_sa = 0; c_din = 0;
        #1;
        check("reset_a_bvec", a_bvec, 8'h00);
        check("reset_b_dout", b_dout, 8'h00);
        check("reset_c_bvec", c_bvec, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: fill R1..R7 with 0xA5, reserve R5 on the last write, then reset mid-cycle
        for (int i = 1; i < 8; i++) begin
            step_ab(1'b1, 3'(i), 8'hA5, (i == 7), 3'd5, 3'd0, 3'd0);
        end
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd7, 3'd5);
        check("fill_a_d7", a_dout, 8'hA5);
        check("fill_a_sbusy5", a_sbusy, 1'b1);
        check("fill_a_bvec", a_bvec, 8'h20);
        #1 rst = 1'b1;
        #1;
        check("midrst_a_d7", a_dout, 8'h00);
        check("midrst_a_s5", a_sout, 8'h00);
        check("midrst_a_bvec", a_bvec, 8'h00);
        check("midrst_b_d7", b_dout, 8'h00);
        check("midrst_b_bvec", b_bvec, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // 2: basic write then read
        step_ab(1'b1, 3'd3, 8'h3C, 1'b0, 3'd0, 3'd0, 3'd0);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 3'd5);
        check("basic_a_d3", a_dout, 8'h3C);
        check("basic_a_s5", a_sout, 8'h00);
        check("basic_b_d3", b_dout, 8'h3C);

        // 3: write and reserve R0
        step_ab(1'b1, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd1, 3'd1);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        check("zero_a_d0", a_dout, 8'h00);
        check("zero_a_dbusy", a_dbusy, 1'b0);
        check("zero_a_bvec", a_bvec, 8'h00);
        check("zero_b_d0", b_dout, 8'hFF);
        check("zero_b_dbusy", b_dbusy, 1'b1);
        check("zero_b_bvec", b_bvec, 8'h01);
        // clear B's R0 reservation with a plain write
        step_ab(1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 3'd1, 3'd1);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
        check("zero_b_bvec_clr", b_bvec, 8'h00);

        // 4: bypass on both ports
        step_ab(1'b1, 3'd2, 8'h77, 1'b0, 3'd0, 3'd2, 3'd2);
        check("byp_a_d2", a_dout, 8'h77);
        check("byp_a_s2", a_sout, 8'h77);
        check("byp_b_d2", b_dout, 8'h00);
        check("byp_b_s2", b_sout, 8'h00);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd2);
        check("byp_b_d2_next", b_dout, 8'h77);

        // 5: scoreboard on R4 (R4 holds 0 after the mid-run reset)
        step_ab(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 3'd0);
        check("sb_a_dbusy_same", a_dbusy, 1'b0);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd0);
        check("sb_a_dbusy", a_dbusy, 1'b1);
        check("sb_a_stall", a_stall, 1'b1);
        check("sb_a_bvec", a_bvec, 8'h10);
        check("sb_b_stall", b_stall, 1'b1);
        step_ab(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 3'd4, 3'd0);
        check("sb_a_wr_d4", a_dout, 8'h11);
        check("sb_a_wr_dbusy", a_dbusy, 1'b0);
        check("sb_a_wr_stall", a_stall, 1'b0);
        check("sb_b_wr_d4", b_dout, 8'h00);
        check("sb_b_wr_dbusy", b_dbusy, 1'b1);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd4, 3'd4);
        check("sb_a_after_d4", a_dout, 8'h11);
        check("sb_a_after_bvec", a_bvec, 8'h00);
        check("sb_b_after_sbusy", b_sbusy, 1'b0);

        // 6: reserve and write R6 in the same cycle
        step_ab(1'b1, 3'd6, 8'h42, 1'b1, 3'd6, 3'd0, 3'd0);
        step_ab(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd6);
        check("col_a_d6", a_dout, 8'h42);
        check("col_a_dbusy", a_dbusy, 1'b1);
        check("col_a_bvec", a_bvec, 8'h40);
        check("col_b_bvec", b_bvec, 8'h40);
        check("col_b_s6", b_sout, 8'h42);

        // Wide instance: N=16, R_SIZE=4
        step_c(1'b1, 4'd11, 16'hBEEF, 1'b0, 4'd0, 4'd0, 4'd0);
        step_c(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd11, 4'd13);
        check("wide_d11", c_dout, 16'hBEEF);
        check("wide_s13", c_sout, 16'h0000);
        step_c(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 4'd0, 4'd0);
        step_c(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0, 4'd15);
        check("wide_sbusy15", c_sbusy, 1'b1);
        check("wide_stall", c_stall, 1'b1);
        check("wide_bvec", c_bvec, 16'h8000);
        step_c(1'b1, 4'd15, 16'h1234, 1'b0, 4'd0, 4'd15, 4'd0);
        check("wide_byp_d15", c_dout, 16'h1234);
        check("wide_byp_dbusy", c_dbusy, 1'b0);
        step_c(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd15, 4'd11);
        check("wide_after_d15", c_dout, 16'h1234);
        check("wide_after_bvec", c_bvec, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
